// File: rtl/game_status.sv
// Breakout game-session tracker: lives, BCD score, session FSM and a 4-digit seven-segment scan.
// Optional GAME_STATUS_FLASH_EN blinks the display in the OVER and WON states.
module game_status #(
  parameter int LIVES        = 3,
  parameter int SCAN_BITS    = 16,
  parameter int FLASH_FRAMES = 30
) (
  input  logic       pxl_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       lose,
  input  logic       win,
  input  logic       vsync,
  input  logic [7:0] block_status1,
  input  logic [7:0] block_status2,
  input  logic [7:0] block_status3,
  output logic [2:0] lives,
  output logic [7:0] score,
  output logic       playing,
  output logic       game_over,
  output logic       game_won,
  output logic [6:0] seg,
  output logic [3:0] an
);

  typedef enum logic [2:0] {IDLE, PLAY, SERVE, OVER, WON} state_t;

  state_t         state_q, state_d;
  logic [2:0]     lives_d;
  logic [7:0]     score_d, score_add;
  logic           lose_q, win_q, vsync_q;
  logic           lose_rise, win_rise, frame_tick;
  logic [23:0]    blocks, snapshot;
  logic [6:0]     score_bin, score_sum;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [1:0]     digit_idx, digit_next;
  logic [3:0]     digit_val;
  logic           digit_blank, blank_all;

  function automatic logic [4:0] popcount24(input logic [23:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 24; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 7'h40;
      4'd1: glyph = 7'h79;
      4'd2: glyph = 7'h24;
      4'd3: glyph = 7'h30;
      4'd4: glyph = 7'h19;
      4'd5: glyph = 7'h12;
      4'd6: glyph = 7'h02;
      4'd7: glyph = 7'h78;
      4'd8: glyph = 7'h00;
      4'd9: glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign blocks     = {block_status3, block_status2, block_status1};
  assign lose_rise  = lose & ~lose_q;
  assign win_rise   = win & ~win_q;
  assign frame_tick = vsync_q & ~vsync;

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      lose_q   <= 1'b0;
      win_q    <= 1'b0;
      vsync_q  <= 1'b1;
      snapshot <= '0;
    end else begin
      lose_q  <= lose;
      win_q   <= win;
      vsync_q <= vsync;
      if (frame_tick) snapshot <= blocks;
    end
  end

  // Score is added in binary, saturated at 24, then converted back to BCD.
  always_comb begin
    score_bin = 7'(score[7:4]) * 7'd10 + 7'(score[3:0]);
    score_sum = score_bin + 7'(popcount24(snapshot & ~blocks));
    if (score_sum > 7'd24) score_sum = 7'd24;
    if (score_sum >= 7'd20)      score_add = {4'd2, 4'(score_sum - 7'd20)};
    else if (score_sum >= 7'd10) score_add = {4'd1, 4'(score_sum - 7'd10)};
    else                         score_add = {4'd0, score_sum[3:0]};
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives;
    score_d = score;
    case (state_q)
      IDLE:  if (start) state_d = PLAY;
      PLAY: begin
        if (frame_tick) score_d = score_add;
        if (win_rise) begin
          state_d = WON;
        end else if (lose_rise) begin
          lives_d = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
          state_d = (lives_d == 3'd0) ? OVER : SERVE;
        end
      end
      SERVE: if (start) state_d = PLAY;
      OVER, WON: begin
        if (start) begin
          state_d = IDLE;
          lives_d = 3'(LIVES);
          score_d = 8'h00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lives     <= 3'(LIVES);
      score     <= 8'h00;
      playing   <= 1'b0;
      game_over <= 1'b0;
      game_won  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives     <= lives_d;
      score     <= score_d;
      playing   <= (state_q == PLAY);
      game_over <= (state_q == OVER);
      game_won  <= (state_q == WON);
    end
  end

`ifdef GAME_STATUS_FLASH_EN
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
  logic [FLASH_W-1:0] flash_cnt;
  logic               blink;

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt <= '0;
      blink     <= 1'b0;
    end else if (state_q == IDLE) begin
      flash_cnt <= '0;
      blink     <= 1'b0;
    end else if ((state_q == OVER || state_q == WON) && frame_tick) begin
      if (flash_cnt == FLASH_W'(FLASH_FRAMES - 1)) begin
        flash_cnt <= '0;
        blink     <= ~blink;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end
  assign blank_all = blink;
`else
  logic unused_flash;
  assign unused_flash = ^FLASH_FRAMES;
  assign blank_all    = 1'b0;
`endif

  // an and seg are both registered from the upcoming digit index so they always agree.
  assign digit_next = (&scan_cnt) ? digit_idx + 2'd1 : digit_idx;

  always_comb begin
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    case (digit_next)
      2'd0: digit_val = score[3:0];
      2'd1: digit_val = score[7:4];
      2'd2: digit_blank = 1'b1;
      2'd3: digit_val = {1'b0, lives};
      default: digit_blank = 1'b1;
    endcase
  end

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      an        <= 4'b1110;
      seg       <= 7'h40;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
      digit_idx <= digit_next;
      an        <= blank_all ? 4'b1111 : ~(4'b0001 << digit_next);
      seg       <= digit_blank ? 7'h7F : glyph(digit_val);
    end
  end

endmodule

// File: tb/tb_game_status.sv
// Directed, table-driven bench for game_status with a 2-bit scan counter so digit rotation is quick.
module tb_game_status;

  typedef struct {
    logic        start;
    logic        lose;
    logic        win;
    logic        vsync;
    logic [23:0] blocks;
    logic [2:0]  exp_lives;
    logic [7:0]  exp_score;
    logic        exp_playing;
    logic        exp_over;
    logic        exp_won;
  } vec_t;

  logic       pxl_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, lose = 1'b0, win = 1'b0, vsync = 1'b1;
  logic [7:0] block_status1 = 8'hFF, block_status2 = 8'hFF, block_status3 = 8'hFF;
  logic [2:0] lives;
  logic [7:0] score;
  logic       playing, game_over, game_won;
  logic [6:0] seg;
  logic [3:0] an;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[22];

  game_status #(.LIVES(3), .SCAN_BITS(2), .FLASH_FRAMES(2)) dut (
    .pxl_clk(pxl_clk), .reset_n(reset_n), .start(start), .lose(lose), .win(win),
    .vsync(vsync), .block_status1(block_status1), .block_status2(block_status2),
    .block_status3(block_status3), .lives(lives), .score(score), .playing(playing),
    .game_over(game_over), .game_won(game_won), .seg(seg), .an(an)
  );

  always #20 pxl_clk = ~pxl_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [6:0] expGlyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      7: return 7'b1111000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkStatus(input string tag, input vec_t v);
    checkOutput({tag, " lives"}, int'(lives), int'(v.exp_lives));
    checkOutput({tag, " score"}, int'(score), int'(v.exp_score));
    checkOutput({tag, " playing"}, int'(playing), int'(v.exp_playing));
    checkOutput({tag, " game_over"}, int'(game_over), int'(v.exp_over));
    checkOutput({tag, " game_won"}, int'(game_won), int'(v.exp_won));
  endtask

  // Levels are held three cycles then released; start is a single-cycle pulse.
  task automatic applyStimulus(input vec_t v);
    @(posedge pxl_clk); #1;
    {block_status3, block_status2, block_status1} = v.blocks;
    lose  = v.lose;
    win   = v.win;
    vsync = v.vsync ? 1'b0 : 1'b1;
    start = v.start;
    @(posedge pxl_clk); #1;
    start = 1'b0;
    repeat (2) @(posedge pxl_clk);
    #1;
    lose  = 1'b0;
    win   = 1'b0;
    vsync = 1'b1;
    repeat (3) @(posedge pxl_clk);
    @(negedge pxl_clk);
  endtask

  task automatic runScanTest();
    logic [3:0] prev_an;
    logic [3:0] exp_an[4];
    int         exp_dig[4];
    bit         found;
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_dig = '{7, 1, -1, 2};
    found   = 1'b0;
    @(negedge pxl_clk);
    prev_an = an;
    for (int c = 0; c < 32 && !found; c++) begin
      @(negedge pxl_clk);
      if (an == 4'b1110 && prev_an == 4'b0111) found = 1'b1;
      else prev_an = an;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL scan sync: an never stepped 0111 -> 1110, last an=%b", an);
    end else begin
      for (int d = 0; d < 4; d++) begin
        checkOutput($sformatf("scan an[%0d]", d), int'(an), int'(exp_an[d]));
        checkOutput($sformatf("scan seg[%0d]", d), int'(seg), int'(expGlyph(exp_dig[d])));
        repeat (4) @(negedge pxl_clk);
      end
    end
  endtask

  initial begin
    vec_t v;
    //           start lose win vsync blocks      lives score pl ov wn
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF, 3'd3, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFF8, 3'd3, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hFFF000, 3'd3, 8'h12, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hFFF000, 3'd3, 8'h12, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'hFFF000, 3'd2, 8'h12, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hFF0000, 3'd2, 8'h12, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hFF0000, 3'd2, 8'h12, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hE00000, 3'd2, 8'h17, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'hE00000, 3'd1, 8'h17, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hE00000, 3'd1, 8'h17, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'hE00000, 3'd0, 8'h17, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'hE00000, 3'd0, 8'h17, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hE00000, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF, 3'd3, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h00000F, 3'd3, 8'h20, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 3'd3, 8'h20, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFC00, 3'd3, 8'h24, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 3'd3, 8'h24, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 3'd3, 8'h24, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge pxl_clk);
    checkOutput("reset lives", int'(lives), 3);
    checkOutput("reset score", int'(score), 0);
    checkOutput("reset playing", int'(playing), 0);
    checkOutput("reset game_over", int'(game_over), 0);
    checkOutput("reset game_won", int'(game_won), 0);
    checkOutput("reset an", int'(an), int'(4'b1110));
    checkOutput("reset seg", int'(seg), int'(expGlyph(0)));
    @(posedge pxl_clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i]);
      checkStatus($sformatf("vec%0d", i), vecs[i]);
      if (i == 8) runScanTest();
    end

    v = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF, 3'd3, 8'h00, 1'b1, 1'b0, 1'b0};
    applyStimulus(v);
    checkStatus("restart", v);
    v = '{1'b0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0};
    applyStimulus(v);
    checkStatus("pre-reset lose", v);

    @(posedge pxl_clk); #7;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset lives", int'(lives), 3);
    checkOutput("async reset score", int'(score), 0);
    checkOutput("async reset playing", int'(playing), 0);
    checkOutput("async reset an", int'(an), int'(4'b1110));
    checkOutput("async reset seg", int'(seg), int'(expGlyph(0)));
    repeat (2) @(posedge pxl_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_status.md
Name: game_status

Overview:
- Downstream consumer of the breakout core's outputs (lose, win, start, block_status1..3, vsync).
- Tracks remaining lives and score (blocks destroyed) and runs the game-session FSM.
- Drives a 4-digit multiplexed common-anode seven-segment display.
- Clocked by the 25 MHz pixel clock.

Parameters:
- LIVES, 3, lives loaded at session start (1..7).
- SCAN_BITS, 16, width of the digit-scan counter; digit advances when the counter wraps.
- FLASH_FRAMES, 30, vsync frames per blink half-period (used only with the optional feature).

Ports:
- pxl_clk  in  1  25 MHz pixel clock, sole clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse from the button controller.
- lose  in  1  level from the collision logic: ball missed the paddle.
- win  in  1  level from the collision logic: all blocks cleared.
- vsync  in  1  VGA vsync, active-low, synchronous to pxl_clk.
- block_status1  in  8  block alive bits, row 1 (1 = alive).
- block_status2  in  8  row 2.
- block_status3  in  8  row 3.
- lives  out  3  remaining lives.
- score  out  8  packed BCD score, 00..24.
- playing  out  1  high in PLAY state.
- game_over  out  1  high in OVER state.
- game_won  out  1  high in WON state.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low, one-hot-low.

Behaviour:
- Reset values: state = IDLE, lives = LIVES, score = 8'h00, playing/game_over/game_won = 0, an = 4'b1110, seg = glyph of digit 0, scan counter = 0.
- Edge detection: lose and win are registered, and a rising edge is detected on each (1-cycle internal pulse). A vsync frame tick is generated on the vsync falling edge.
- FSM states:
  - IDLE: start -> PLAY.
  - PLAY: win_rise -> WON. lose_rise -> lives decremented; if the new lives value is 0 -> OVER, else -> SERVE.
  - SERVE: start -> PLAY. lives unchanged.
  - OVER: start -> IDLE; lives reloaded to LIVES, score cleared to 00.
  - WON: start -> IDLE; lives reloaded to LIVES, score cleared to 00.
- Simultaneous win_rise and lose_rise in PLAY: win has priority; lives are not decremented.
- start in PLAY is ignored.
- Status outputs are registered decodes of the state: 1 cycle after the transition.
- Score update:
  - On each frame tick in PLAY, compare the concatenated 24-bit block status against a snapshot taken at the previous tick.
  - cleared = snapshot & ~current. Add popcount(cleared), range 0..24, to score using BCD adjust.
  - The score saturates at BCD 24 and never wraps.
  - The snapshot updates on every frame tick in every state, so blocks regenerated in IDLE are not counted.
  - Score is frozen outside PLAY.
- Lives decrement floors at 0; it never wraps to 7.
- Display scan:
  - The free-running SCAN_BITS counter advances a 2-bit digit index on wrap.
  - Index 0: score ones. Index 1: score tens. Index 2: blank (seg = 7'h7F). Index 3: lives.
  - an and seg are registered together; there is no ghost cycle where an and seg mismatch.
- Reset asserted mid-game returns everything immediately and asynchronously to reset values.

Optional Feature:
- Macro: GAME_STATUS_FLASH_EN.
- Defined: in OVER and WON, a frame counter toggles a blink flag every FLASH_FRAMES frame ticks; while the flag is set, an = 4'b1111. The counter and flag clear on entry to IDLE.
- Undefined: no blinking; the display is always driven; FLASH_FRAMES is unused.

Test Plan:
- Reset, then start pulse -> state PLAY, playing = 1 one cycle later, lives = 3, score = 00.
- In PLAY, clear 3 bits of block_status1, then one vsync falling edge -> score = 8'h03. Clear 9 more -> score = 8'h12 (BCD).
- Three lose rising edges, each followed by a start pulse -> lives 2 (SERVE), 1 (SERVE), 0 (OVER); game_over = 1; a fourth lose pulse leaves lives = 0.
- win and lose rise in the same cycle in PLAY -> WON, lives unchanged; then start -> IDLE, lives = 3, score = 00.
- SCAN_BITS = 2 with score = 8'h17, lives = 2 -> an cycles 1110, 1101, 1011, 0111 with seg = glyph 7, glyph 1, 7F, glyph 2.
- With GAME_STATUS_FLASH_EN defined, FLASH_FRAMES = 2, in OVER -> an = 1111 for 2 frames, driven for 2 frames, repeating; reset_n low mid-blink -> all outputs return to reset values immediately.
